dm_store_buffer: RTL and testbench



---
 rtl/dm_store_buffer_pkg.sv | 37 +++
 rtl/dm_store_buffer_if.sv | 16 +
 rtl/dm_wbuf_fifo.sv | 87 ++++++++
 rtl/dm_store_buffer.sv | 78 +++++++
 tb/tb_dm_store_buffer.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/dm_store_buffer_pkg.sv
// Shared definitions for the data-memory store buffer: byte-enable encodings,
// default sizes and the lane helpers used at enqueue and drain.
package dm_store_buffer_pkg;

    localparam int DEPTH_DEF     = 4;
    localparam int MEM_WORDS_DEF = 1024;

    localparam logic [3:0] BT_WORD    = 4'b1111;
    localparam logic [3:0] BT_HALF_LO = 4'b0011;
    localparam logic [3:0] BT_HALF_HI = 4'b1100;
    localparam logic [3:0] BT_BYTE0   = 4'b0001;
    localparam logic [3:0] BT_BYTE1   = 4'b0010;
    localparam logic [3:0] BT_BYTE2   = 4'b0100;
    localparam logic [3:0] BT_BYTE3   = 4'b1000;

    // Replicate the raw rt value so the enabled lanes carry the right bytes.
    function automatic logic [31:0] align_lanes(input logic [31:0] wd, input logic [3:0] bt);
        logic [31:0] res;
        case (bt)
            BT_WORD:                res = wd;
            BT_HALF_LO, BT_HALF_HI: res = {2{wd[15:0]}};
            default:                res = {4{wd[7:0]}};
        endcase
        return res;
    endfunction

    function automatic logic [31:0] merge_lanes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  be);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[b*8 +: 8] = be[b] ? new_w[b*8 +: 8] : old_w[b*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/dm_store_buffer_if.sv
// MEM-stage data-memory bus between the pipeline and the store buffer.
interface dm_store_buffer_if;
    logic        MemWrite_M;
    logic        MemRead_M;
    logic [31:0] Addr_M;
    logic [31:0] WD_M;
    logic [3:0]  Bit_Type;
    logic [31:0] RD_M;
    logic        Stall_M;
    logic        Empty;

    modport master (output MemWrite_M, MemRead_M, Addr_M, WD_M, Bit_Type,
                    input  RD_M, Stall_M, Empty);
    modport slave  (input  MemWrite_M, MemRead_M, Addr_M, WD_M, Bit_Type,
                    output RD_M, Stall_M, Empty);
endinterface

// File: rtl/dm_wbuf_fifo.sv
// Circular store FIFO (DEPTH a power of two, >= 2) with a parallel word-index
// compare over all valid entries.
module dm_wbuf_fifo
    import dm_store_buffer_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int IDX_W = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [IDX_W-1:0] push_idx,
    input  logic [31:0]      push_data,
    input  logic [3:0]       push_be,
    input  logic             pop,
    input  logic             lookup_en,
    input  logic [IDX_W-1:0] lookup_idx,
    output logic             hit,
    output logic             empty,
    output logic [IDX_W-1:0] head_idx,
    output logic [31:0]      head_data,
    output logic [3:0]       head_be
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] valid_r;
    logic [IDX_W-1:0] idx_r  [DEPTH];
    logic [31:0]      data_r [DEPTH];
    logic [3:0]       be_r   [DEPTH];
    logic [PTR_W-1:0] head_r;
    logic [PTR_W-1:0] tail_r;
    logic [CNT_W-1:0] count_r;

    // Entry storage and pointers; push after pop so a full push+pop reuses the slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_r <= {DEPTH{1'b0}};
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                idx_r[i]  <= {IDX_W{1'b0}};
                data_r[i] <= 32'h0;
                be_r[i]   <= 4'h0;
            end
        end else begin
            if (pop) begin
                valid_r[head_r] <= 1'b0;
                head_r          <= head_r + PTR_W'(1'b1);
            end
            if (push) begin
                valid_r[tail_r] <= 1'b1;
                idx_r[tail_r]   <= push_idx;
                data_r[tail_r]  <= push_data;
                be_r[tail_r]    <= push_be;
                tail_r          <= tail_r + PTR_W'(1'b1);
            end
        end
    end

    // Occupancy count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r <= {CNT_W{1'b0}};
        end else begin
            case ({push, pop})
                2'b10:   count_r <= count_r + CNT_W'(1'b1);
                2'b01:   count_r <= count_r - CNT_W'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Parallel compare of the load word index against every pending entry.
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            hit = hit | (lookup_en & valid_r[i] & (idx_r[i] == lookup_idx));
        end
    end

    assign empty     = (count_r == {CNT_W{1'b0}});
    assign head_idx  = idx_r[head_r];
    assign head_data = data_r[head_r];
    assign head_be   = be_r[head_r];

endmodule

// File: rtl/dm_store_buffer.sv
// MEM-stage data memory: store FIFO draining into an owned single-port RAM,
// loads take the port first and stall only on a pending same-word store.
module dm_store_buffer
    import dm_store_buffer_pkg::*;
#(
    parameter int DEPTH     = DEPTH_DEF,
    parameter int MEM_WORDS = MEM_WORDS_DEF
) (
    input  logic             clk,
    input  logic             reset,
    dm_store_buffer_if.slave bus
);
    localparam int IDX_W = $clog2(MEM_WORDS);

    logic [31:0]      mem_r [MEM_WORDS];
    logic [IDX_W-1:0] idx_s;
    logic             hit_s;
    logic             empty_s;
    logic             drain_s;
    logic             enq_s;
    logic [IDX_W-1:0] head_idx_s;
    logic [31:0]      head_data_s;
    logic [3:0]       head_be_s;
    logic [31:0]      rd_s;
    logic             unused_addr_s;

    assign idx_s         = bus.Addr_M[IDX_W+1:2];
    assign unused_addr_s = ^{bus.Addr_M[31:IDX_W+2], bus.Addr_M[1:0]};

    // A hitting load frees the port for the drain that unblocks it.
    assign drain_s = ~empty_s & (~bus.MemRead_M | hit_s);
    assign enq_s   = bus.MemWrite_M & ~hit_s;

    dm_wbuf_fifo #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (enq_s),
        .push_idx   (idx_s),
        .push_data  (align_lanes(bus.WD_M, bus.Bit_Type)),
        .push_be    (bus.Bit_Type),
        .pop        (drain_s),
        .lookup_en  (bus.MemRead_M),
        .lookup_idx (idx_s),
        .hit        (hit_s),
        .empty      (empty_s),
        .head_idx   (head_idx_s),
        .head_data  (head_data_s),
        .head_be    (head_be_s)
    );

    // Data RAM: cleared on reset, byte-lane write of the drained head entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MEM_WORDS; i++) begin
                mem_r[i] <= 32'h0;
            end
        end else if (drain_s) begin
            mem_r[head_idx_s] <= merge_lanes(mem_r[head_idx_s], head_data_s, head_be_s);
        end
    end

    // Asynchronous load read, forced to zero while idle or stalled.
    always_comb begin
        if (bus.MemRead_M && !hit_s) begin
            rd_s = mem_r[idx_s];
        end else begin
            rd_s = 32'h0;
        end
    end

    assign bus.RD_M    = rd_s;
    assign bus.Stall_M = hit_s;
    assign bus.Empty   = empty_s;

endmodule

// File: tb/tb_dm_store_buffer.sv
// Randomized bench for dm_store_buffer against a queue-plus-array reference
// model, with directed store/load scenarios in front.
module tb_dm_store_buffer;
    import dm_store_buffer_pkg::*;

    localparam int WORDS = 1024;

    typedef struct {
        int unsigned idx;
        logic [31:0] data;
        logic [3:0]  be;
    } st_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    dm_store_buffer_if bus ();

    dm_store_buffer #(.DEPTH(4), .MEM_WORDS(WORDS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [31:0] ref_mem [WORDS];
    st_t         pend_q [$];
    logic        st_o;
    logic [31:0] rd_o;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] lane_data(input logic [31:0] wd, input logic [3:0] bt);
        int n;
        n = $countones(bt);
        if (n == 4) return wd;
        if (n == 2) return {wd[15:0], wd[15:0]};
        return {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
    endfunction

    task automatic clear_model();
        pend_q.delete();
        for (int i = 0; i < WORDS; i++) ref_mem[i] = 32'h0;
    endtask

    // One MEM-stage cycle: called #1 after a rising edge, returns #1 after the next.
    task automatic step(input logic mw, input logic mr, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] bt, input string tag,
                        output logic obs_stall, output logic [31:0] obs_rd);
        int unsigned w;
        logic        exp_stall;
        logic [31:0] exp_rd;
        bus.MemWrite_M = mw;
        bus.MemRead_M  = mr;
        bus.Addr_M     = addr;
        bus.WD_M       = wd;
        bus.Bit_Type   = bt;
        w = addr[11:2];
        exp_stall = 1'b0;
        foreach (pend_q[i]) if (mr && pend_q[i].idx == w) exp_stall = 1'b1;
        exp_rd = (mr && !exp_stall) ? ref_mem[w] : 32'h0;
        @(negedge clk);
        obs_stall = bus.Stall_M;
        obs_rd    = bus.RD_M;
        check_eq({tag, ".stall"}, {31'h0, bus.Stall_M}, {31'h0, exp_stall});
        check_eq({tag, ".rd"}, bus.RD_M, exp_rd);
        check_eq({tag, ".empty"}, {31'h0, bus.Empty}, {31'h0, pend_q.size() == 0});
        @(posedge clk);
        if (pend_q.size() != 0 && (!mr || exp_stall)) begin
            st_t h;
            h = pend_q.pop_front();
            for (int b = 0; b < 4; b++)
                if (h.be[b]) ref_mem[h.idx][b*8 +: 8] = h.data[b*8 +: 8];
        end
        if (mw && !exp_stall) pend_q.push_back('{w, lane_data(wd, bt), bt});
        #1;
    endtask

    task automatic idle(input string tag);
        step(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, tag, st_o, rd_o);
    endtask

    // Issue a load and retry it while stalled, within a cycle budget.
    task automatic load_retry(input logic [31:0] addr, input string tag, output int stalls,
                              output logic [31:0] data);
        logic s;
        stalls = 0;
        data   = 32'h0;
        s      = 1'b1;
        for (int k = 0; k < 8 && s; k++) begin
            step(1'b0, 1'b1, addr, 32'h0, BT_WORD, tag, s, data);
            if (s) stalls++;
        end
        check_eq({tag, ".bounded"}, {31'h0, s}, 32'h0);
    endtask

    logic [3:0] bt_tab [6];
    int         stalls;
    logic [31:0] data;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bt_tab = '{BT_WORD, BT_HALF_LO, BT_HALF_HI, BT_BYTE0, BT_BYTE2, BT_BYTE3};
        bus.MemWrite_M = 1'b0;
        bus.MemRead_M  = 1'b1;
        bus.Addr_M     = 32'h10;
        bus.WD_M       = 32'h0;
        bus.Bit_Type   = 4'h0;
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset.empty", {31'h0, bus.Empty}, 32'h1);
        check_eq("reset.stall", {31'h0, bus.Stall_M}, 32'h0);
        check_eq("reset.rd", bus.RD_M, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // SW then LW to the same word.
        step(1'b1, 1'b0, 32'h10, 32'h12345678, BT_WORD, "sw10", st_o, rd_o);
        load_retry(32'h10, "lw10", stalls, data);
        check_eq("lw10.stalls", stalls, 32'd1);
        check_eq("lw10.data", data, 32'h12345678);
        check_eq("lw10.empty_after", {31'h0, bus.Empty}, 32'h1);

        // SB into lane 1.
        step(1'b1, 1'b0, 32'h21, 32'h000000AB, BT_BYTE1, "sb21", st_o, rd_o);
        idle("idle_sb");
        step(1'b0, 1'b1, 32'h20, 32'h0, BT_WORD, "lw20", st_o, rd_o);
        check_eq("lw20.stall", {31'h0, st_o}, 32'h0);
        check_eq("lw20.data", rd_o, 32'h0000AB00);

        // Two halfwords into one word.
        step(1'b1, 1'b0, 32'h32, 32'h0000BEEF, BT_HALF_HI, "sh32", st_o, rd_o);
        step(1'b1, 1'b0, 32'h30, 32'h0000CAFE, BT_HALF_LO, "sh30", st_o, rd_o);
        idle("idle_sh");
        step(1'b0, 1'b1, 32'h30, 32'h0, BT_WORD, "lw30", st_o, rd_o);
        check_eq("lw30.data", rd_o, 32'hBEEFCAFE);

        // Back-to-back stores then a load of the last one.
        step(1'b1, 1'b0, 32'h40, 32'hA0A0A0A0, BT_WORD, "sw40", st_o, rd_o);
        step(1'b1, 1'b0, 32'h44, 32'hB1B1B1B1, BT_WORD, "sw44", st_o, rd_o);
        step(1'b1, 1'b0, 32'h48, 32'hC2C2C2C2, BT_WORD, "sw48", st_o, rd_o);
        load_retry(32'h48, "lw48", stalls, data);
        check_eq("lw48.data", data, 32'hC2C2C2C2);

        // Unrelated loads block drains; interleaved stores keep flowing.
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 1'b0, 32'h50 + 32'(k * 4), 32'h11110000 + 32'(k), BT_WORD, "sw5x", st_o, rd_o);
            step(1'b0, 1'b1, 32'h100, 32'h0, BT_WORD, "lw100", st_o, rd_o);
        end
        step(1'b1, 1'b0, 32'h60, 32'h55667788, BT_WORD, "swfull", st_o, rd_o);
        check_eq("swfull.no_stall", {31'h0, st_o}, 32'h0);
        load_retry(32'h50, "lw50", stalls, data);
        check_eq("lw50.data", data, 32'h11110000);

        // Reset with a store pending.
        step(1'b1, 1'b0, 32'h70, 32'h99999999, BT_WORD, "sw70", st_o, rd_o);
        bus.MemWrite_M = 1'b0;
        bus.MemRead_M  = 1'b1;
        bus.Addr_M     = 32'h70;
        #1;
        check_eq("prereset.stall", {31'h0, bus.Stall_M}, 32'h1);
        reset = 1'b1;
        #1;
        check_eq("midreset.stall", {31'h0, bus.Stall_M}, 32'h0);
        check_eq("midreset.empty", {31'h0, bus.Empty}, 32'h1);
        clear_model();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        step(1'b0, 1'b1, 32'h10, 32'h0, BT_WORD, "lw10_post", st_o, rd_o);
        check_eq("lw10_post.data", rd_o, 32'h0);
        step(1'b0, 1'b1, 32'h70, 32'h0, BT_WORD, "lw70_post", st_o, rd_o);
        check_eq("lw70_post.data", rd_o, 32'h0);

        // Random traffic over a small word window with random high/low address bits.
        for (int n = 0; n < 400; n++) begin
            int unsigned op;
            logic [31:0] addr;
            op   = $urandom_range(0, 2);
            addr = ($urandom & 32'hFFFFF000) | ((32'd32 + $urandom_range(0, 7)) << 2)
                   | 32'($urandom_range(0, 3));
            step(op == 1, op == 2, addr, $urandom, bt_tab[$urandom_range(0, 5)], "rnd", st_o, rd_o);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
